// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle add/sub/logic/shift ops, shift-add multiply over WIDTH cycles,
// valid/ready handshakes on both sides with registered result and flags.
module alu_multicycle #(
   parameter int WIDTH = 64,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       cntrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out
);

   localparam logic [3:0] OpPassB = 4'b0000;
   localparam logic [3:0] OpAdd   = 4'b0010;
   localparam logic [3:0] OpSub   = 4'b0011;
   localparam logic [3:0] OpAnd   = 4'b0100;
   localparam logic [3:0] OpOr    = 4'b0101;
   localparam logic [3:0] OpXor   = 4'b0110;
   localparam logic [3:0] OpShl   = 4'b0111;
   localparam logic [3:0] OpShr   = 4'b1000;
   localparam logic [3:0] OpMul   = 4'b1001;

   localparam logic [SHW-1:0] LastIter = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StMul, StDone} state_t;

   state_t           state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [SHW-1:0]   cnt;

   logic             accept;
   logic [WIDTH-1:0] b_op;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic             alu_cy;
   logic [WIDTH-1:0] acc_next;

   assign in_ready  = (state == StIdle) || ((state == StDone) && out_ready);
   assign out_valid = (state == StDone);
   assign accept    = in_valid && in_ready;

   // Subtraction is A + ~B + 1, so the carry-in doubles as the subtract select.
   always_comb begin
      b_op    = (cntrl == OpSub) ? ~B : B;
      sum     = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, (cntrl == OpSub)};
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_cy  = 1'b0;
      case (cntrl)
         OpPassB: alu_res = B;
         OpAdd, OpSub: begin
            alu_res = sum[WIDTH-1:0];
            alu_cy  = sum[WIDTH];
            alu_ovf = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OpAnd:   alu_res = A & B;
         OpOr:    alu_res = A | B;
         OpXor:   alu_res = A ^ B;
         OpShl:   alu_res = A << B[SHW-1:0];
         OpShr:   alu_res = A >> B[SHW-1:0];
         default: alu_res = '0;
      endcase
   end

   assign acc_next = mplier[0] ? (acc + mcand) : acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= StIdle;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         result    <= '0;
         negative  <= 1'b0;
         zero      <= 1'b1;
         overflow  <= 1'b0;
         carry_out <= 1'b0;
      end else begin
         case (state)
            StIdle, StDone: begin
               if (accept) begin
                  if (cntrl == OpMul) begin
                     state  <= StMul;
                     mcand  <= A;
                     mplier <= B;
                     acc    <= '0;
                     cnt    <= '0;
                  end else begin
                     state     <= StDone;
                     result    <= alu_res;
                     negative  <= alu_res[WIDTH-1];
                     zero      <= (alu_res == '0);
                     overflow  <= alu_ovf;
                     carry_out <= alu_cy;
                  end
               end else if ((state == StDone) && out_ready) begin
                  state <= StIdle;
               end
            end
            StMul: begin
               // One multiplier bit per cycle; the last iteration lands directly in result.
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == LastIter) begin
                  state     <= StDone;
                  result    <= acc_next;
                  negative  <= acc_next[WIDTH-1];
                  zero      <= (acc_next == '0);
                  overflow  <= 1'b0;
                  carry_out <= 1'b0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle, exercising a 64-bit and an 8-bit instance.
module tb_alu_multicycle;

   logic        clk = 1'b0;
   logic        reset;
   int          checks = 0;
   int          errors = 0;

   logic        in_valid64, in_ready64, out_valid64, out_ready64;
   logic [63:0] a64, b64, res64;
   logic [3:0]  c64;
   logic        n64, z64, o64, cy64;
   logic [4:0]  f64;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  a8, b8, res8;
   logic [3:0]  c8;
   logic        n8, z8, o8, cy8;
   logic [4:0]  f8;

   assign f64 = {out_valid64, n64, z64, o64, cy64};
   assign f8  = {out_valid8, n8, z8, o8, cy8};

   always #5 clk = ~clk;

   alu_multicycle #(.WIDTH(64)) dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
      .A(a64), .B(b64), .cntrl(c64), .out_valid(out_valid64), .out_ready(out_ready64),
      .result(res64), .negative(n64), .zero(z64), .overflow(o64), .carry_out(cy64)
   );

   alu_multicycle #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .A(a8), .B(b8), .cntrl(c8), .out_valid(out_valid8), .out_ready(out_ready8),
      .result(res8), .negative(n8), .zero(z8), .overflow(o8), .carry_out(cy8)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      in_valid64 = 1'b1; a64 = 64'd7; b64 = 64'd9; c64 = 4'b0010; out_ready64 = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; c8 = '0; out_ready8 = 1'b1;
      step();
      step();
      reset = 1'b0;
      in_valid64 = 1'b0;
      checks++;
      if (res64 !== 64'd0) begin
         errors++; $display("FAIL reset_result: got %h want 0", res64);
      end
      checks++;
      if (f64 !== 5'b00100) begin
         errors++; $display("FAIL reset_flags: got %b want 00100", f64);
      end
      checks++;
      if (in_ready64 !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready64);
      end
      step();
      checks++;
      if (out_valid64 !== 1'b0) begin
         errors++; $display("FAIL reset_no_accept: got out_valid %b want 0", out_valid64);
      end
   endtask

   task automatic test_add_overflow;
      a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'd1; c64 = 4'b0010; in_valid64 = 1'b1;
      step();
      in_valid64 = 1'b0;
      checks++;
      if (res64 !== 64'h8000_0000_0000_0000) begin
         errors++; $display("FAIL add_ovf_result: got %h want 8000000000000000", res64);
      end
      checks++;
      if (f64 !== 5'b11010) begin
         errors++; $display("FAIL add_ovf_flags: got %b want 11010", f64);
      end
      step();
      checks++;
      if (out_valid64 !== 1'b0) begin
         errors++; $display("FAIL add_ovf_release: got out_valid %b want 0", out_valid64);
      end
   endtask

   task automatic test_sub;
      a64 = 64'd5; b64 = 64'd5; c64 = 4'b0011; in_valid64 = 1'b1;
      step();
      checks++;
      if ({res64, f64} !== {64'd0, 5'b10101}) begin
         errors++; $display("FAIL sub_equal: got %h/%b want 0/10101", res64, f64);
      end
      a64 = 64'd3; b64 = 64'd5;
      step();
      in_valid64 = 1'b0;
      checks++;
      if ({res64, f64} !== {64'hFFFF_FFFF_FFFF_FFFE, 5'b11000}) begin
         errors++; $display("FAIL sub_borrow: got %h/%b want fffffffffffffffe/11000", res64, f64);
      end
      step();
   endtask

   task automatic test_misc_ops;
      in_valid64 = 1'b1; a64 = 64'h5555; b64 = 64'h1234; c64 = 4'b0000;
      step();
      checks++;
      if ({res64, f64} !== {64'h1234, 5'b10000}) begin
         errors++; $display("FAIL pass_b: got %h/%b want 1234/10000", res64, f64);
      end
      c64 = 4'b1111;
      step();
      checks++;
      if ({res64, f64} !== {64'd0, 5'b10100}) begin
         errors++; $display("FAIL illegal_op: got %h/%b want 0/10100", res64, f64);
      end
      a64 = 64'h8000_0000_0000_0000; b64 = 64'd63; c64 = 4'b1000;
      step();
      checks++;
      if (res64 !== 64'd1) begin
         errors++; $display("FAIL shr_63: got %h want 1", res64);
      end
      a64 = 64'hABCD; b64 = 64'h40; c64 = 4'b0111;
      step();
      in_valid64 = 1'b0;
      checks++;
      if (res64 !== 64'hABCD) begin
         errors++; $display("FAIL shl_zero: got %h want abcd", res64);
      end
      step();
   endtask

   task automatic test_mul8;
      a8 = 8'h0F; b8 = 8'h11; c8 = 4'b1001; in_valid8 = 1'b1;
      checks++;
      if (in_ready8 !== 1'b1) begin
         errors++; $display("FAIL mul8_ready_before: got %b want 1", in_ready8);
      end
      step();
      // Garbage on the inputs while busy must not disturb the multiply.
      a8 = 8'hFF; b8 = 8'hFF; c8 = 4'b0010;
      for (int i = 1; i <= 8; i++) begin
         checks++;
         if ({in_ready8, out_valid8} !== 2'b00) begin
            errors++; $display("FAIL mul8_busy_%0d: got ready/valid %b%b want 00", i, in_ready8,
                               out_valid8);
         end
         step();
      end
      in_valid8 = 1'b0;
      checks++;
      if ({res8, f8} !== {8'hFF, 5'b11000}) begin
         errors++; $display("FAIL mul8_result: got %h/%b want ff/11000", res8, f8);
      end
      step();
      checks++;
      if (out_valid8 !== 1'b0) begin
         errors++; $display("FAIL mul8_release: got out_valid %b want 0", out_valid8);
      end
   endtask

   task automatic test_mul64;
      int lat;
      a64 = 64'h1_0000_0001; b64 = 64'hFFFF_FFFF; c64 = 4'b1001; in_valid64 = 1'b1;
      step();
      in_valid64 = 1'b0;
      lat = 1;
      while (out_valid64 !== 1'b1 && lat < 100) begin
         step();
         lat++;
      end
      checks++;
      if (lat !== 65) begin
         errors++; $display("FAIL mul64_latency: got %0d want 65", lat);
      end
      checks++;
      if ({res64, f64} !== {64'hFFFF_FFFF_FFFF_FFFF, 5'b11000}) begin
         errors++; $display("FAIL mul64_result: got %h/%b want ffffffffffffffff/11000", res64, f64);
      end
      step();
   endtask

   task automatic test_shift_hold;
      a64 = 64'd1; b64 = 64'h41; c64 = 4'b0111; in_valid64 = 1'b1; out_ready64 = 1'b0;
      step();
      in_valid64 = 1'b0;
      checks++;
      if ({res64, f64} !== {64'd2, 5'b10000}) begin
         errors++; $display("FAIL shl_mod: got %h/%b want 2/10000", res64, f64);
      end
      a64 = 64'hDEAD; b64 = 64'd4;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({res64, f64, in_ready64} !== {64'd2, 5'b10000, 1'b0}) begin
            errors++; $display("FAIL hold_%0d: got %h/%b ready %b want 2/10000 ready 0", i, res64,
                               f64, in_ready64);
         end
      end
      out_ready64 = 1'b1;
      step();
      checks++;
      if (out_valid64 !== 1'b0) begin
         errors++; $display("FAIL hold_release: got out_valid %b want 0", out_valid64);
      end
   endtask

   task automatic test_back_to_back;
      a64 = 64'hF0F0_F0F0_0000_FFFF; b64 = 64'h0FF0_FF00_FFFF_00FF;
      c64 = 4'b0100; in_valid64 = 1'b1; out_ready64 = 1'b1;
      step();
      checks++;
      if ({res64, f64, in_ready64} !== {64'h00F0_F000_0000_00FF, 5'b10000, 1'b1}) begin
         errors++; $display("FAIL b2b_and: got %h/%b ready %b", res64, f64, in_ready64);
      end
      c64 = 4'b0101;
      step();
      checks++;
      if ({res64, f64} !== {64'hFFF0_FFF0_FFFF_FFFF, 5'b11000}) begin
         errors++; $display("FAIL b2b_or: got %h/%b want fff0fff0ffffffff/11000", res64, f64);
      end
      c64 = 4'b0110;
      step();
      in_valid64 = 1'b0;
      checks++;
      if ({res64, f64} !== {64'hFF00_0FF0_FFFF_FF00, 5'b11000}) begin
         errors++; $display("FAIL b2b_xor: got %h/%b want ff000ff0ffffff00/11000", res64, f64);
      end
      step();
   endtask

   task automatic test_reset_mid_mul;
      a64 = 64'd3; b64 = 64'd5; c64 = 4'b1001; in_valid64 = 1'b1;
      step();
      in_valid64 = 1'b0;
      repeat (9) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({res64, f64, in_ready64} !== {64'd0, 5'b00100, 1'b1}) begin
         errors++; $display("FAIL mid_mul_reset: got %h/%b ready %b want 0/00100 ready 1", res64,
                            f64, in_ready64);
      end
      repeat (70) step();
      checks++;
      if (out_valid64 !== 1'b0) begin
         errors++; $display("FAIL mid_mul_no_result: got out_valid %b want 0", out_valid64);
      end
      a64 = 64'd2; b64 = 64'd3; c64 = 4'b0010; in_valid64 = 1'b1;
      step();
      in_valid64 = 1'b0;
      checks++;
      if ({res64, f64} !== {64'd5, 5'b10000}) begin
         errors++; $display("FAIL post_reset_add: got %h/%b want 5/10000", res64, f64);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_sub();
      test_misc_ops();
      test_mul8();
      test_mul64();
      test_shift_hold();
      test_back_to_back();
      test_reset_mid_mul();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 64, datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width in bits; it is derived from WIDTH and never overridden.
REQ-003 Port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, synchronous active-high reset sampled on the rising edge of clk.
REQ-005 Port in_valid, input, 1 bit, operand/opcode request valid.
REQ-006 Port in_ready, output, 1 bit, block can accept a request this cycle.
REQ-007 Port A, input, WIDTH bits, first operand.
REQ-008 Port B, input, WIDTH bits, second operand (shift amount = B[SHW-1:0]).
REQ-009 Port cntrl, input, 4 bits, operation select.
REQ-010 Port out_valid, output, 1 bit, result and flags valid.
REQ-011 Port out_ready, input, 1 bit, consumer accepts the result.
REQ-012 Port result, output, WIDTH bits, registered operation result.
REQ-013 Port negative, output, 1 bit, equals result[WIDTH-1].
REQ-014 Port zero, output, 1 bit, result equals all-zeros.
REQ-015 Port overflow, output, 1 bit, 2's-complement overflow of add/sub.
REQ-016 Port carry_out, output, 1 bit, carry out of MSB of add/sub.

Function
REQ-017 Opcodes: 0000 result=B; 0010 A+B; 0011 A-B (A + ~B + 1); 0100 A&B; 0101 A|B; 0110 A^B; 0111 logical shift left A by B[SHW-1:0]; 1000 logical shift right A by B[SHW-1:0]; 1001 low WIDTH bits of A*B (unsigned); all other codes give result=0.
REQ-018 Flags overflow and carry_out are computed only for 0010/0011; for every other opcode both are 0.
REQ-019 Flags negative and zero are derived from the final result for every opcode, and all flags are registered together with result.
REQ-020 FSM has three states: IDLE, MUL, DONE.
REQ-021 A handshake occurs when in_valid and in_ready are both 1 on a rising edge; A, B and cntrl are captured at that edge.
REQ-022 in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-023 For a non-multiply opcode, the accept edge registers result and flags and enters DONE, giving out_valid 1 cycle after acceptance.
REQ-024 For opcode 1001, the accept edge enters MUL and the block runs shift-add, one multiplier bit per cycle, for exactly WIDTH cycles.
REQ-025 After the last MUL cycle the block registers result and flags and enters DONE, giving out_valid WIDTH+1 cycles after acceptance.
REQ-026 out_valid = (state==DONE); result and flags hold stable while out_valid=1 and out_ready=0.
REQ-027 In DONE with out_ready=1 and no new handshake, the next state is IDLE.
REQ-028 In DONE with out_ready=1 and a same-cycle handshake, the new request is accepted (back-to-back), giving one single-cycle result per clock.
REQ-029 in_valid is ignored while in MUL; A/B/cntrl input changes during MUL have no effect.
REQ-030 Shift amounts are taken modulo WIDTH (only B[SHW-1:0] used); shift by 0 returns A.
REQ-031 Add/sub wrap modulo 2^WIDTH; carry_out for subtraction = 1 when A >= B unsigned.

Reset
REQ-032 While reset=1 at a rising edge, state goes to IDLE, the MUL iteration counter and accumulator clear, and result=0, negative=0, zero=1, overflow=0, carry_out=0.
REQ-033 Reset asserted mid-MUL or in DONE aborts the operation with no result delivered; out_valid=0 and in_ready=1 on the first cycle after reset deasserts.
REQ-034 An in_valid asserted in the same cycle as reset is not accepted.

Verification
REQ-035 WIDTH=64, cntrl=0010, A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> next cycle out_valid=1, result=0x8000_0000_0000_0000, negative=1, overflow=1, carry_out=0, zero=0.
REQ-036 WIDTH=64, cntrl=0011, A=5, B=5 -> result=0, zero=1, carry_out=1, overflow=0.
REQ-037 WIDTH=8, cntrl=1001, A=0x0F, B=0x11 -> in_ready=0 for 8 MUL cycles, out_valid at cycle 9 after accept, result=0xFF, negative=1, overflow=0, carry_out=0.
REQ-038 WIDTH=64, cntrl=0111, A=1, B=0x41 -> result=2 (shift modulo 64); then out_ready=0 for 3 cycles -> result and flags unchanged, in_ready=0.
REQ-039 WIDTH=64, out_ready held 1 with back-to-back requests 0100, 0101, 0110 -> three consecutive cycles of out_valid with the correct AND/OR/XOR results and overflow=carry_out=0.
REQ-040 WIDTH=64, reset pulsed at MUL cycle 10 -> no out_valid, outputs match the REQ-032 reset values, and a following 0010 with A=2, B=3 gives result=5.
